imem_arbiter: RTL

- Shares the single-port, 64-bit-wide instruction memory between the core fetch port and the program loader write port.
- Each instruction memory word holds two 32-bit instructions.
- After reset, the block holds the core in boot until the loader reports completion.
- In run mode, core fetch has priority. A starvation counter guarantees loader progress for runtime patching and debug writes.

---
 rtl/imem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between the core fetch port
// and the program loader, holding the core in boot until the image is loaded.
module imem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic [DATA_W-1:0] fetch_data_o,
  output logic              fetch_valid_o,
  output logic              fetch_stall_o,
  output logic              core_hold_o,
  input  logic              load_req_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ack_o,
  input  logic              load_done_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_stall_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  // A write that has already waited STARVE_LIMIT-1 cycles reaches the limit
  // at this edge, so the steal happens after exactly STARVE_LIMIT waits.
  localparam logic [CNT_W-1:0] STEAL_AT = CNT_W'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    STEAL
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] starve_cnt, starve_next;
  logic             fetch_grant;
  logic             fetch_valid_q;

  always_comb begin
    state_next    = state;
    starve_next   = starve_cnt;
    fetch_grant   = 1'b0;
    core_hold_o   = 1'b0;
    fetch_stall_o = 1'b1;
    load_ack_o    = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    mem_stall_o   = 1'b0;

    case (state)
      BOOT: begin
        core_hold_o = 1'b1;
        starve_next = '0;
        if (load_req_i) begin
          mem_we_o    = 1'b1;
          mem_addr_o  = load_addr_i;
          mem_wdata_o = load_data_i;
          load_ack_o  = 1'b1;
        end else if (load_done_i) begin
          state_next = RUN;
        end
      end

      RUN: begin
        fetch_stall_o = 1'b0;
        if (fetch_req_i) begin
          fetch_grant = 1'b1;
          mem_addr_o  = fetch_addr_i;
          if (load_req_i) begin
            starve_next = starve_cnt + 1'b1;
            if (starve_cnt == STEAL_AT) begin
              state_next = STEAL;
            end
          end else begin
            starve_next = '0;
          end
        end else begin
          starve_next = '0;
          if (load_req_i) begin
            mem_we_o    = 1'b1;
            mem_addr_o  = load_addr_i;
            mem_wdata_o = load_data_i;
            load_ack_o  = 1'b1;
          end
        end
      end

      STEAL: begin
        // Freeze the memory output so the core's last read data survives.
        mem_stall_o = 1'b1;
        starve_next = '0;
        state_next  = RUN;
        if (load_req_i) begin
          mem_we_o    = 1'b1;
          mem_addr_o  = load_addr_i;
          mem_wdata_o = load_data_i;
          load_ack_o  = 1'b1;
        end
      end

      default: begin
        core_hold_o = 1'b1;
        state_next  = BOOT;
      end
    endcase

    // Reset is asynchronous, so kill any grant combinationally while it is high.
    if (reset_i) begin
      fetch_grant = 1'b0;
      load_ack_o  = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_stall_o = 1'b0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= BOOT;
      starve_cnt    <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      state         <= state_next;
      starve_cnt    <= starve_next;
      fetch_valid_q <= fetch_grant;
    end
  end

  assign fetch_valid_o = fetch_valid_q;
  assign fetch_data_o  = mem_rdata_i;

endmodule
